// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
//
// Ports:
//   i_clk, i_reset_n          clock (rising edge), asynchronous active-low reset
//   i_id_*                    decoded instruction, operands and control from ID
//   i_flush                   branch/jump taken in EX; the ID instruction is killed
//   i_ex_stall                EX/MEM not accepting; this register holds
//   o_stall_if_id             combinational hold request for PC and IF/ID
//   o_id_ex_*                 registered instruction fields, addresses and control
//   o_bubble_cnt              saturating count of load-use bubbles inserted
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_id_valid,
    input  logic [XLEN-1:0]   i_id_pc,
    input  logic [XLEN-1:0]   i_id_rs1_data,
    input  logic [XLEN-1:0]   i_id_rs2_data,
    input  logic [XLEN-1:0]   i_id_imm,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic              i_id_RegWrite,
    input  logic              i_id_MemRead,
    input  logic              i_id_MemWrite,
    input  logic              i_id_MemToReg,
    input  logic              i_id_ALUSrc,
    input  logic [3:0]        i_id_ALUOp,
    input  logic              i_flush,
    input  logic              i_ex_stall,
    output logic              o_stall_if_id,
    output logic              o_id_ex_valid,
    output logic [XLEN-1:0]   o_id_ex_pc,
    output logic [XLEN-1:0]   o_id_ex_rs1_data,
    output logic [XLEN-1:0]   o_id_ex_rs2_data,
    output logic [XLEN-1:0]   o_id_ex_imm,
    output logic [REG_AW-1:0] o_id_ex_Rs1,
    output logic [REG_AW-1:0] o_id_ex_Rs2,
    output logic [REG_AW-1:0] o_id_ex_Rd,
    output logic              o_id_ex_RegWrite,
    output logic              o_id_ex_MemRead,
    output logic              o_id_ex_MemWrite,
    output logic              o_id_ex_MemToReg,
    output logic              o_id_ex_ALUSrc,
    output logic [3:0]        o_id_ex_ALUOp,
    output logic [CNT_W-1:0]  o_bubble_cnt
);

    logic hz;
    logic load_en;
    logic bubble;
    logic bump;
    logic keep;

    // A load in EX whose result an ID operand needs cannot be forwarded in
    // time. x0 is never a real dependency, and unused operand fields are
    // ignored because they may hold arbitrary instruction bits.
    assign hz = o_id_ex_valid & o_id_ex_MemRead & (o_id_ex_Rd != '0) & i_id_valid &
                ((i_id_uses_rs1 & (i_id_rs1 == o_id_ex_Rd)) |
                 (i_id_uses_rs2 & (i_id_rs2 == o_id_ex_Rd)));

    // A flush discards the ID instruction, so holding IF/ID would be pointless.
    assign o_stall_if_id = i_reset_n & ~i_flush & (i_ex_stall | hz);

    always_comb begin
        load_en = 1'b1;
        bubble  = 1'b0;
        bump    = 1'b0;
        if (i_flush) begin
            bubble = 1'b1;
        end else if (i_ex_stall) begin
            load_en = 1'b0;
        end else if (hz) begin
            bubble = 1'b1;
            bump   = 1'b1;
        end
    end

    // Control and addresses survive only for a real, non-bubbled instruction.
    assign keep = ~bubble & i_id_valid;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_id_ex_valid    <= 1'b0;
            o_id_ex_pc       <= '0;
            o_id_ex_rs1_data <= '0;
            o_id_ex_rs2_data <= '0;
            o_id_ex_imm      <= '0;
            o_id_ex_Rs1      <= '0;
            o_id_ex_Rs2      <= '0;
            o_id_ex_Rd       <= '0;
            o_id_ex_RegWrite <= 1'b0;
            o_id_ex_MemRead  <= 1'b0;
            o_id_ex_MemWrite <= 1'b0;
            o_id_ex_MemToReg <= 1'b0;
            o_id_ex_ALUSrc   <= 1'b0;
            o_id_ex_ALUOp    <= '0;
        end else if (load_en) begin
            o_id_ex_valid    <= keep;
            o_id_ex_pc       <= bubble ? '0 : i_id_pc;
            o_id_ex_rs1_data <= bubble ? '0 : i_id_rs1_data;
            o_id_ex_rs2_data <= bubble ? '0 : i_id_rs2_data;
            o_id_ex_imm      <= bubble ? '0 : i_id_imm;
            o_id_ex_Rs1      <= keep ? i_id_rs1 : '0;
            o_id_ex_Rs2      <= keep ? i_id_rs2 : '0;
            o_id_ex_Rd       <= keep ? i_id_rd  : '0;
            o_id_ex_RegWrite <= keep & i_id_RegWrite;
            o_id_ex_MemRead  <= keep & i_id_MemRead;
            o_id_ex_MemWrite <= keep & i_id_MemWrite;
            o_id_ex_MemToReg <= keep & i_id_MemToReg;
            o_id_ex_ALUSrc   <= keep & i_id_ALUSrc;
            o_id_ex_ALUOp    <= keep ? i_id_ALUOp : 4'd0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_bubble_cnt <= '0;
        end else if (bump && (o_bubble_cnt != {CNT_W{1'b1}})) begin
            o_bubble_cnt <= o_bubble_cnt + 1'b1;
        end
    end

endmodule
